// File: rtl/fu_opcode_issuer_pkg.sv
// fu_pkg: opcode type and constants, one-hot instruction decode, and the
// issuer FSM state encoding shared by the opcode issuer files.
package fu_pkg;

  typedef logic [2:0] fu_opcode_t;

  localparam fu_opcode_t OP_ADD     = 3'd0;
  localparam fu_opcode_t OP_ADDN    = 3'd1;
  localparam fu_opcode_t OP_AND     = 3'd2;
  localparam fu_opcode_t OP_OR      = 3'd3;
  localparam fu_opcode_t OP_MAX     = 3'd4;
  localparam fu_opcode_t OP_MIN     = 3'd5;
  localparam fu_opcode_t OP_SHR_ADD = 3'd6;
  localparam fu_opcode_t OP_SHL_ADD = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2
  } fu_state_e;

  function automatic logic [7:0] fu_decode(input fu_opcode_t op);
    fu_decode = 8'h01 << op;
  endfunction

endpackage

// File: rtl/fu_opcode_issuer_fifo.sv
// opcode_fifo: synchronous opcode FIFO with push/pop and full/empty flags.
// Pushes while full and pops while empty are ignored.
module opcode_fifo
  import fu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       pop,
  input  logic [2:0] din,
  output logic [2:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  fu_opcode_t      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count_q alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/fu_opcode_issuer.sv
// fu_opcode_issuer: buffers encoded opcodes, drives the one-hot FU instruction,
// samples the FU result after a settle window. FU_ISSUE_COUNT_EN adds issue_count.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | nothing in flight; pop the FIFO head as soon as one exists
//   ST_DRIVE | instruction held; settle down-counter runs to terminal 0
//   ST_HOLD  | result registered, out_valid high until consumer accepts
module fu_opcode_issuer
  import fu_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opcode,
  output logic [7:0]        instruction,
  input  logic [DATA_W-1:0] fu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_opcode,
  output logic [DATA_W-1:0] out_data,
`ifdef FU_ISSUE_COUNT_EN
  output logic [15:0]       issue_count,
`endif
  output logic              busy
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC - 1);

  fu_state_e         state_q, state_d;
  logic [7:0]        instr_q, instr_d;
  logic [3:0]        cnt_q, cnt_d;
  fu_opcode_t        cur_op_q, cur_op_d;
  logic              out_valid_q, out_valid_d;
  fu_opcode_t        out_opcode_q, out_opcode_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic       pop;
  fu_opcode_t fifo_dout;
  logic       fifo_full, fifo_empty;

  opcode_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (pop),
    .din   (in_opcode),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    cnt_d        = cnt_q;
    cur_op_d     = cur_op_q;
    out_valid_d  = out_valid_q;
    out_opcode_d = out_opcode_q;
    out_data_d   = out_data_q;
    pop          = 1'b0;
    unique case (state_q)
      ST_IDLE: pop = !fifo_empty;
      ST_DRIVE: begin
        if (cnt_q == 4'd0) begin
          out_valid_d  = 1'b1;
          out_data_d   = fu_result;
          out_opcode_d = cur_op_q;
          state_d      = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          pop         = !fifo_empty;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A pop from IDLE or from a HOLD handshake both start a fresh settle window.
    if (pop) begin
      instr_d  = fu_decode(fifo_dout);
      cur_op_d = fifo_dout;
      cnt_d    = SETTLE_INIT;
      state_d  = ST_DRIVE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      instr_q      <= 8'h01;
      cnt_q        <= '0;
      cur_op_q     <= '0;
      out_valid_q  <= 1'b0;
      out_opcode_q <= '0;
      out_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      instr_q      <= instr_d;
      cnt_q        <= cnt_d;
      cur_op_q     <= cur_op_d;
      out_valid_q  <= out_valid_d;
      out_opcode_q <= out_opcode_d;
      out_data_q   <= out_data_d;
    end
  end

  assign in_ready    = rst_n && !fifo_full;
  assign instruction = instr_q;
  assign out_valid   = out_valid_q;
  assign out_opcode  = out_opcode_q;
  assign out_data    = out_data_q;
  assign busy        = (state_q != ST_IDLE) || !fifo_empty;

`ifdef FU_ISSUE_COUNT_EN
  logic [15:0] issue_cnt_q, issue_cnt_d;

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    if (out_valid_q && out_ready && (issue_cnt_q != 16'hFFFF))
      issue_cnt_d = issue_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) issue_cnt_q <= '0;
    else        issue_cnt_q <= issue_cnt_d;
  end

  assign issue_count = issue_cnt_q;
`endif

endmodule

// File: tb/tb_fu_opcode_issuer.sv
// Bench for fu_opcode_issuer: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_fu_opcode_issuer;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  // main instance, SETTLE_CYC = 1
  logic       in_valid = 1'b0;
  logic [2:0] in_opcode = 3'd0;
  logic       out_ready = 1'b0;
  logic       fu_mode = 1'b1;
  logic [7:0] fu_rand = 8'h00;
  logic       in_ready, out_valid, busy;
  logic [7:0] instruction, out_data, fu_result;
  logic [2:0] out_opcode;

  // second instance, SETTLE_CYC = 3
  logic       in_valid3 = 1'b0;
  logic [2:0] in_opcode3 = 3'd0;
  logic       out_ready3 = 1'b1;
  logic [7:0] fu3 = 8'h00;
  logic       in_ready3, out_valid3, busy3;
  logic [7:0] instruction3, out_data3;
  logic [2:0] out_opcode3;

`ifdef FU_ISSUE_COUNT_EN
  logic [15:0] issue_count, issue_count3;
`endif

  // Functional unit stand-in with fixed operands A=0x30, C=0x12.
  function automatic logic [7:0] fu_func(input logic [7:0] ins);
    logic [7:0] a, c;
    a = 8'h30;
    c = 8'h12;
    case (ins)
      8'h01:   fu_func = a + c;
      8'h02:   fu_func = a + ~c;
      8'h04:   fu_func = a & c;
      8'h08:   fu_func = a | c;
      8'h10:   fu_func = (a > c) ? a : c;
      8'h20:   fu_func = (a < c) ? a : c;
      8'h40:   fu_func = (a >> 1) + c;
      8'h80:   fu_func = (a << 1) + c;
      default: fu_func = 8'h00;
    endcase
  endfunction

  assign fu_result = fu_mode ? fu_func(instruction) : fu_rand;

  fu_opcode_issuer #(.DATA_W(8), .DEPTH(DEPTH), .SETTLE_CYC(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .instruction(instruction), .fu_result(fu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_data(out_data),
`ifdef FU_ISSUE_COUNT_EN
    .issue_count(issue_count),
`endif
    .busy(busy)
  );

  fu_opcode_issuer #(.DATA_W(8), .DEPTH(DEPTH), .SETTLE_CYC(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_opcode(in_opcode3), .instruction(instruction3), .fu_result(fu3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_opcode(out_opcode3),
    .out_data(out_data3),
`ifdef FU_ISSUE_COUNT_EN
    .issue_count(issue_count3),
`endif
    .busy(busy3)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of waiting opcodes, one opcode in flight with a
  // remaining-settle count, and one pending result.
  logic [2:0] m_q[$];
  bit         m_infl = 1'b0;
  logic [2:0] m_op = 3'd0;
  int         m_left = 0;
  bit         m_rv = 1'b0;
  logic [2:0] m_rop = 3'd0;
  logic [7:0] m_rdata = 8'h00;
  logic [7:0] m_instr = 8'h01;
  int         m_hs = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_infl  = 1'b0;
      m_rv    = 1'b0;
      m_rop   = 3'd0;
      m_rdata = 8'h00;
      m_instr = 8'h01;
      m_hs    = 0;
    end else begin
      bit         can_push, do_pop;
      logic [7:0] fu_now;
      can_push = in_valid && (m_q.size() < DEPTH);
      fu_now   = fu_mode ? fu_func(m_instr) : fu_rand;
      do_pop   = 1'b0;
      if (m_rv) begin
        if (out_ready) begin
          m_rv = 1'b0;
          m_hs++;
          do_pop = (m_q.size() > 0);
        end
      end else if (m_infl) begin
        if (m_left == 0) begin
          m_rv    = 1'b1;
          m_rdata = fu_now;
          m_rop   = m_op;
          m_infl  = 1'b0;
        end else begin
          m_left--;
        end
      end else begin
        do_pop = (m_q.size() > 0);
      end
      if (do_pop) begin
        m_op    = m_q.pop_front();
        m_infl  = 1'b1;
        m_left  = 0;
        m_instr = 8'h01 << m_op;
      end
      if (can_push) m_q.push_back(in_opcode);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", in_ready, rst_n && (m_q.size() < DEPTH));
      check("instruction", instruction, m_instr);
      check("out_valid", out_valid, m_rv);
      check("out_opcode", out_opcode, m_rop);
      check("out_data", out_data, m_rdata);
      check("busy", busy, m_infl || m_rv || (m_q.size() > 0));
`ifdef FU_ISSUE_COUNT_EN
      check("issue_count", issue_count, (m_hs > 65535) ? 65535 : m_hs);
`endif
    end
  end

  // Result / instruction logs for ordering and spacing checks.
  logic [2:0] res_op[$];
  int         res_cyc[$];
  logic [7:0] instr_log[$];
  logic [7:0] prev_instr = 8'h01;
  bit         log_en = 1'b0;
  int         cyc = 0;

  always @(negedge clk) begin
    #1;
    cyc++;
    if (rst_n && out_valid && out_ready) begin
      res_op.push_back(out_opcode);
      res_cyc.push_back(cyc);
    end
    if (log_en && (instruction !== prev_instr)) instr_log.push_back(instruction);
    prev_instr = instruction;
  end

  // Called at a negedge; returns at the negedge after the push edge.
  task automatic push(input logic [2:0] op);
    int n;
    n = 0;
    in_valid  = 1'b1;
    in_opcode = op;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("push_timeout", 32'd1, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int cnt);
    int n;
    n = 0;
    while (res_op.size() < cnt && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("result_count", res_op.size(), cnt);
  endtask

  initial begin
    logic [2:0] bp_ops [5];
    bp_ops = '{3'd3, 3'd1, 3'd6, 3'd4, 3'd7};

    // reset
    #1 rst_n = 1'b0;
    #2 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_instruction", instruction, 8'h01);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);
`ifdef FU_ISSUE_COUNT_EN
    check("issue_count_rst", issue_count, 16'd0);
`endif

    // single op: opcode 5 -> MIN(0x30,0x12)
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_opcode = 3'd5;
    @(posedge clk) #1;
    in_valid = 1'b0;
    @(posedge clk) #1;
    check("single_instr", instruction, 8'h20);
    check("single_ov_early", out_valid, 1'b0);
    @(posedge clk) #1;
    check("single_ov", out_valid, 1'b1);
    check("single_op", out_opcode, 3'd5);
    check("single_data", out_data, 8'h12);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("single_idle_busy", busy, 1'b0);
`ifdef FU_ISSUE_COUNT_EN
    check("issue_count_one", issue_count, 16'd1);
`endif

    // decode sweep
    res_op.delete();
    res_cyc.delete();
    instr_log.delete();
    log_en    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(3'(i));
    wait_results(8);
    log_en    = 1'b0;
    out_ready = 1'b0;
    check("sweep_instr_count", instr_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < res_op.size()) check("sweep_op", res_op[i], i);
      if (i < instr_log.size()) check("sweep_instr", instr_log[i], 32'h1 << i);
      if (i > 0 && i < res_cyc.size()) check("sweep_spacing", res_cyc[i] - res_cyc[i-1], 2);
    end

    // backpressure / full
    res_op.delete();
    for (int i = 0; i < 5; i++) push(bp_ops[i]);
    in_valid  = 1'b1;
    in_opcode = 3'd2;
    check("bp_full_in_ready", in_ready, 1'b0);
    check("bp_busy", busy, 1'b1);
    repeat (20) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_opcode", out_opcode, 3'd3);
      check("bp_out_data", out_data, 8'h32);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_results(5);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      if (i < res_op.size()) check("bp_order", res_op[i], bp_ops[i]);

    // reset while a result is pending and another opcode is queued
    push(3'd5);
    push(3'd0);
    repeat (3) @(negedge clk);
    check("mid_pre_ov", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_instr", instruction, 8'h01);
    check("mid_rst_ov", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk) #1;
    check("mid_post_in_ready", in_ready, 1'b1);
    check("mid_post_busy", busy, 1'b0);

    // SETTLE_CYC = 3 instance
    @(negedge clk);
    in_valid3  = 1'b1;
    in_opcode3 = 3'd2;
    out_ready3 = 1'b0;
    fu3        = 8'h11;
    @(posedge clk) #1;
    @(negedge clk);
    in_valid3 = 1'b0;
    @(posedge clk) #1;
    check("s3_instr_1", instruction3, 8'h04);
    check("s3_ov_1", out_valid3, 1'b0);
    @(negedge clk);
    fu3 = 8'hAA;
    @(posedge clk) #1;
    check("s3_instr_2", instruction3, 8'h04);
    check("s3_ov_2", out_valid3, 1'b0);
    @(posedge clk) #1;
    check("s3_instr_3", instruction3, 8'h04);
    check("s3_ov_3", out_valid3, 1'b0);
    @(negedge clk);
    fu3 = 8'h55;
    @(posedge clk) #1;
    check("s3_ov", out_valid3, 1'b1);
    check("s3_op", out_opcode3, 3'd2);
    check("s3_data", out_data3, 8'h55);
    @(negedge clk);
    out_ready3 = 1'b1;
    @(negedge clk);
    check("s3_idle_busy", busy3, 1'b0);

    // randomized traffic
    fu_mode = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      int p_rdy;
      @(negedge clk);
      p_rdy     = (i < 1000) ? 50 : ((i < 2000) ? 15 : 95);
      in_valid  = ($urandom_range(0, 99) < 60);
      in_opcode = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 99) < p_rdy);
      fu_rand   = 8'($urandom);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (30) @(negedge clk);
    check("final_busy", busy, 1'b0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
